// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped UART transmitter (8N1) fed by a byte FIFO.
// Latency: a byte written into an empty FIFO with the line idle starts its start bit one clock later.
// Backpressure: none on the bus; a write to a full FIFO is dropped and latches the sticky ovf flag.
//
// Optional feature macro: UART_PARITY_EN (adds an even-parity bit, frame becomes 11 bits).
//
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   ce, we, addr        IO-bus chip enable, write enable, byte address (addr[3:2] decoded)
//   wtData, rdData      IO-bus write data, combinational read data
//   txd                 registered serial output, idles high
//   busy                frame in progress or FIFO non-empty
//
// Register map (addr[3:2]):
//   0  write: TX data, wtData[7:0] pushed into the FIFO
//   1  write: wtData[3]=1 clears ovf
//      read : {24'b0, count[3:0], ovf, busy, full, empty}
`timescale 1ns/1ps
module io_uart_tx #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wtData,
  output logic [31:0] rdData,
  output logic        txd,
  output logic        busy
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [4:0]  DEPTH_C = 5'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          empty, full;
  logic          wr_sel, ctl_sel, push, pop;

  // ---------------------------------------------------------------- transmitter
  state_t        state_q;
  logic [15:0]   cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          txd_q;
`ifdef UART_PARITY_EN
  logic          parity_q;
`endif

  assign empty   = (count_q == 5'd0);
  assign full    = (count_q == DEPTH_C);
  assign wr_sel  = ce && we && (addr[3:2] == 2'd0);
  assign ctl_sel = ce && we && (addr[3:2] == 2'd1);

  // Fullness is the registered value, so a pop on the same edge never makes room for the write.
  assign push = wr_sel && !full;

  // The FSM takes a byte either from IDLE or on the last cycle of a stop bit, which is what
  // makes back-to-back frames contiguous.
  assign pop = !empty && ((state_q == IDLE) || ((state_q == STOP) && (cnt_q == 16'd0)));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    // A dropped write wins over a clear in the same cycle.
    if (wr_sel && full)               ovf_d = 1'b1;
    else if (ctl_sel && wtData[3])    ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: contents are only visible through the reset pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wtData[7:0];
  end

  // ---------------------------------------------------------------- FSM
  // cnt_q is loaded with CLK_DIV-1 at the start of every bit; the bit ends on the edge where it is 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
`ifdef UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else if (pop) begin
      shift_q   <= mem_q[rd_ptr_q];
`ifdef UART_PARITY_EN
      parity_q  <= ^mem_q[rd_ptr_q];
`endif
      bit_idx_q <= '0;
      cnt_q     <= DIV_M1;
      txd_q     <= 1'b0;
      state_q   <= START;
    end else begin
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
        end
        START: begin
          if (cnt_q == 16'd0) begin
            txd_q     <= shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= '0;
            cnt_q     <= DIV_M1;
            state_q   <= DATA;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        DATA: begin
          if (cnt_q == 16'd0) begin
            cnt_q <= DIV_M1;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
`ifdef UART_PARITY_EN
              txd_q     <= parity_q;
              state_q   <= PARITY;
`else
              txd_q     <= 1'b1;
              state_q   <= STOP;
`endif
            end else begin
              txd_q     <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (cnt_q == 16'd0) begin
            txd_q   <= 1'b1;
            cnt_q   <= DIV_M1;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
`endif
        STOP: begin
          // Reaching here with cnt_q==0 means the FIFO was empty (otherwise pop fired).
          if (cnt_q == 16'd0) state_q <= IDLE;
          else                cnt_q   <= cnt_q - 16'd1;
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign txd  = txd_q;
  assign busy = (state_q != IDLE) || !empty;

  // ---------------------------------------------------------------- read path
  always_comb begin
    rdData = 32'h0;
    if (ce && !we && (addr[3:2] == 2'd1))
      rdData = {24'h0, count_q[3:0], ovf_q, busy, full, empty};
  end

  logic unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], wtData[31:8]};

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: randomized scoreboard bench for io_uart_tx (CLK_DIV=4, FIFO_DEPTH=8).
// Expected bytes and frame start times come from a frame-level model of the FIFO and line.
// A separate UART receiver process decodes txd and compares against the queues.
`timescale 1ns/1ps
module tb_io_uart_tx;

  localparam int D     = 4;
  localparam int DEPTH = 8;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * D;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce = 1'b0, we = 1'b0;
  logic [31:0] addr = 32'h0, wtData = 32'h0;
  logic [31:0] rdData;
  logic        txd, busy;

  io_uart_tx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr),
    .wtData(wtData), .rdData(rdData), .txd(txd), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Scoreboard: bytes in acceptance order, and the edge at which each frame must start.
  logic [7:0] expq[$];
  int         exp_t[$];

  // Frame-level model.
  int edge_n   = 0;
  int m_cnt    = 0;
  bit m_ovf    = 1'b0;
  int next_pop = 0;
  int last_pop = 0;
  bit m_active = 1'b0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", nm, act, exp, edge_n);
    end
  endfunction

  function automatic bit m_busy();
    return (m_cnt > 0) || (m_active && (edge_n < last_pop + FRAME));
  endfunction

  function automatic logic [31:0] m_status();
    return {24'h0, 4'(m_cnt), m_ovf, m_busy(), (m_cnt == DEPTH), (m_cnt == 0)};
  endfunction

  // One clock edge of the model: the line takes a byte whenever the FIFO holds one and the
  // previous frame (if any) has finished; a write is taken if the FIFO was not full before the edge.
  function automatic void model_edge(input logic c, input logic w, input logic [31:0] a,
                                     input logic [31:0] d);
    bit pop, full_b;
    edge_n++;
    if (rst !== 1'b1) return;
    pop    = (m_cnt > 0) && (edge_n >= next_pop);
    full_b = (m_cnt == DEPTH);
    if (pop) begin
      m_cnt--;
      last_pop = edge_n;
      next_pop = edge_n + FRAME;
      m_active = 1'b1;
      exp_t.push_back(edge_n);
    end
    if (c && w && a[3:2] == 2'd0) begin
      if (full_b) m_ovf = 1'b1;
      else begin
        m_cnt++;
        expq.push_back(d[7:0]);
      end
    end else if (c && w && a[3:2] == 2'd1 && d[3]) begin
      m_ovf = 1'b0;
    end
  endfunction

  task automatic cycle(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    ce = c; we = w; addr = a; wtData = d;
    @(posedge clk);
    model_edge(c, w, a, d);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_read(input logic c, input logic w, input logic [31:0] a, input string nm);
    ce = c; we = w; addr = a; wtData = 32'h0;
    #1;
    check(nm, rdData, (c && !w && a[3:2] == 2'd1) ? m_status() : 32'h0);
  endtask

  task automatic drain();
    for (int k = 0; k < 4000 && m_busy(); k++) begin
      cycle(1'b0, 1'b0, 32'h0, 32'h0);
      check("busy_track", {31'h0, busy}, {31'h0, m_busy()});
    end
    idle(2);
    check("drain_busy", {31'h0, busy}, 32'h0);
    check("drain_txd", {31'h0, txd}, 32'h1);
    check("drain_queue", expq.size() + exp_t.size(), 32'h0);
  endtask

  task automatic do_reset();
    ce = 1'b0; we = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_async_txd", {31'h0, txd}, 32'h1);
    check("rst_async_busy", {31'h0, busy}, 32'h0);
    expq.delete();
    exp_t.delete();
    m_cnt = 0; m_ovf = 1'b0; m_active = 1'b0; next_pop = 0;
    cycle(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    check_read(1'b1, 1'b0, 32'h4, "status_after_rst");
  endtask

  // Receiver: samples txd every cycle of a frame and checks every bit cell.
  initial begin : monitor
    logic [NB-1:0] pat, got;
    logic [7:0]    b;
    bit            bad, aborted, unexp;
    int            t_exp;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && txd === 1'b0) begin
        unexp = (expq.size() == 0);
        b = 8'h00;
        if (!unexp) b = expq.pop_front();
        t_exp = -1;
        if (exp_t.size() > 0) t_exp = exp_t.pop_front();
        n_chk++;
        if (unexp) begin
          n_fail++;
          $display("FAIL frame_unexpected: start bit after edge %0d with no byte queued", edge_n);
        end else if (edge_n != t_exp) begin
          n_fail++;
          $display("FAIL frame_start: start bit after edge %0d, expected after edge %0d", edge_n, t_exp);
        end
`ifdef UART_PARITY_EN
        pat = {1'b1, ^b, b, 1'b0};
`else
        pat = {1'b1, b, 1'b0};
`endif
        got = '0;
        bad = 1'b0;
        aborted = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
          if (i > 0) @(negedge clk);
          if (rst !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (i % D == D / 2) got[i / D] = txd;
          if (txd !== pat[i / D]) bad = 1'b1;
        end
        if (!aborted && !unexp) begin
          n_chk++;
          if (bad) begin
            n_fail++;
            $display("FAIL frame_bits: byte 0x%02h got %b expected %b (bit0 = start)", b, got, pat);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit flag;
    int r, n;
    rst = 1'b1;
    #2 rst = 1'b0;
    idle(3);
    check("reset_txd", {31'h0, txd}, 32'h1);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check_read(1'b1, 1'b0, 32'h4, "reset_status");
    rst = 1'b1;

    // Single byte, written on the very first edge after reset release.
    cycle(1'b1, 1'b1, 32'h0, 32'h55);
    check("start_not_yet", {31'h0, txd}, 32'h1);
    idle(1);
    check("start_latency", {31'h0, txd}, 32'h0);
    drain();

    // Three back-to-back bytes: contiguous frames, one already popped.
    cycle(1'b1, 1'b1, 32'h0, 32'h01);
    cycle(1'b1, 1'b1, 32'h0, 32'h02);
    cycle(1'b1, 1'b1, 32'h0, 32'h03);
    check_read(1'b1, 1'b0, 32'h4, "status_count2");
    drain();

    // Overflow: ten back-to-back writes, clear with bit3=0 is ignored, bit3=1 clears.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 32'h0, 32'h10 + i);
    check_read(1'b1, 1'b0, 32'h4, "status_full_ovf");
    check("ovf_model", {31'h0, m_ovf}, 32'h1);
    cycle(1'b1, 1'b1, 32'h4, 32'h07);
    check_read(1'b1, 1'b0, 32'h4, "status_ovf_kept");
    cycle(1'b1, 1'b1, 32'h4, 32'h08);
    check_read(1'b1, 1'b0, 32'h4, "status_ovf_clr");
    drain();

    // Reset at cycle 15 of a frame.
    cycle(1'b1, 1'b1, 32'h0, 32'hA5);
    cycle(1'b1, 1'b1, 32'h0, 32'h3C);
    idle(15);
    do_reset();
    flag = 1'b0;
    for (int k = 0; k < 60; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 32'h0);
      if (txd !== 1'b1 || busy !== 1'b0) flag = 1'b1;
    end
    check("no_residual_bits", {31'h0, flag}, 32'h0);

    // Parity-relevant bytes (odd and even weight).
    cycle(1'b1, 1'b1, 32'h0, 32'h07);
    cycle(1'b1, 1'b1, 32'h0, 32'h03);
    drain();

    // Reads that must return zero.
    check_read(1'b0, 1'b0, 32'h4, "read_ce0");
    idle(1);
    check_read(1'b1, 1'b0, 32'h0, "read_off0");
    idle(1);
    check_read(1'b1, 1'b1, 32'h4, "read_we1");
    idle(1);
    check_read(1'b1, 1'b0, 32'hC, "read_off3");
    idle(1);

    // Randomized traffic.
    for (int it = 0; it < 1500; it++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        cycle(1'b1, 1'b1, 32'h0, $urandom);
      end else if (r < 6) begin
        n = $urandom_range(1, 10);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b1, {$urandom} & 32'hFFFF_FFF3, $urandom);
      end else if (r < 8) begin
        cycle(1'b1, 1'b1, 32'h4, $urandom);
      end else if (r < 20) begin
        check_read($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom, "rand_read");
        cycle(1'b0, 1'b0, 32'h0, 32'h0);
      end else begin
        cycle(1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    drain();
    check_read(1'b1, 1'b0, 32'h4, "final_status");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
